sram_nibble_arbiter: RTL and testbench
======================================

SRAM_NIBBLE_ARBITER -- requirements
Module: sram_nibble_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port cpu_out, input, 8 bits: CPU io_out bus.
- bit7=1: address phase, [6:0] = address.
- bit7=0: [5] = write-enable, active-low; [3:0] = write nibble.
REQ-004 SHALL have port cpu_nibble, output, 4 bits: read nibble returned to the CPU io_in.
REQ-005 SHALL have port cpu_hold, output, 1 bit: high holds the CPU in reset.
REQ-006 SHALL have ports host_req (in 1), host_valid (in 1), host_we (in 1), host_addr (in 7), host_wdata (in 8): host ownership request and single-access command.
REQ-007 SHALL have ports host_gnt (out 1), host_rdata (out 8), host_rvalid (out 1): host grant and read return.
REQ-008 SHALL have ports mem_addr (out 7), mem_we (out 1), mem_wdata (out 8), mem_rdata (in 8): 128x8 SRAM with asynchronous read and synchronous write.
REQ-009 SHALL have port wp_fault, output, 1 bit: sticky write-protect violation flag.

Function
REQ-010 SHALL implement the state machine RUN -> DRAIN -> HOST -> RELEASE -> RUN.
REQ-011 In RUN, when cpu_out[7]=1 the block SHALL latch cpu_out[6:0] into the address register; mem_addr SHALL equal the latched address.
REQ-012 Phase flop: in RUN it SHALL clear when cpu_out[7]=1 and toggle on every other cycle.
REQ-013 cpu_nibble SHALL be mem_rdata[7:4] when phase=0 and mem_rdata[3:0] when phase=1; it is combinational.
REQ-014 CPU write, when cpu_out[7]=0 and cpu_out[5]=0:
- phase=1: store cpu_out[3:0] in a low-nibble register.
- phase=0: mem_we=1 with mem_wdata = {cpu_out[3:0], low-nibble register}.
REQ-015 RUN->DRAIN SHALL occur when host_req is sampled 1; CPU writes SHALL continue to be honoured in DRAIN.
REQ-016 DRAIN->HOST SHALL occur on the first cycle with cpu_out[7]=1, or after 4 DRAIN cycles, whichever comes first.
REQ-017 cpu_hold SHALL be 1 in HOST and RELEASE and 0 otherwise; host_gnt SHALL be 1 only in HOST.
REQ-018 In HOST, CPU writes SHALL be ignored, and mem_addr, mem_we and mem_wdata SHALL be driven combinationally from host_addr, host_valid&host_we and host_wdata.
REQ-019 A host read (host_valid=1, host_we=0) SHALL register mem_rdata into host_rdata, with host_rvalid=1 exactly one cycle later; back-to-back accesses are allowed every cycle.
REQ-020 HOST->RELEASE SHALL occur when host_req is sampled 0; host_valid in that cycle SHALL be ignored.
REQ-021 RELEASE SHALL last exactly 1 cycle, then enter RUN with the phase flop cleared.
REQ-022 If host_req drops during DRAIN, the block SHALL return to RUN with no cpu_hold pulse.
REQ-023 Address arithmetic SHALL be 7-bit with no wrap logic; bit 7 of any 8-bit field SHALL never reach mem_addr.

Reset
REQ-024 While rst=0 the block SHALL be held in these values:
- state=RUN, phase=0, address=0, low-nibble=0.
- cpu_hold=1, host_gnt=0, host_rvalid=0, host_rdata=0, mem_we=0, wp_fault=0.
REQ-025 Reset asserted mid-HOST or mid-DRAIN SHALL abort any access, with no memory write in that cycle.
REQ-026 The first cycle after rst=1 SHALL be RUN with cpu_hold=0.

Configuration
REQ-027 Macro SRAM_WRPROT_EN defined:
- CPU writes to addresses 0x00-0x3F SHALL be suppressed (mem_we=0) and SHALL set wp_fault.
- wp_fault clears only on reset; host writes are never protected.
REQ-028 Macro SRAM_WRPROT_EN undefined: all CPU writes SHALL pass and wp_fault SHALL be tied to 0.

Verification
REQ-029 Reset, then cpu_out=0x85 with mem[0x05]=0xF1 -> mem_addr=0x05, cpu_nibble=0xF, then 0x1 on the next cycle.
REQ-030 CPU write to 0x77: cpu_out=0xF7, then 0x0A (phase=1), then 0x02 (phase=0) -> mem[0x77]=0x2A, mem_we high for exactly one cycle.
REQ-031 host_req=1 during RUN with an address phase 2 cycles later -> DRAIN for 2 cycles, then cpu_hold=1 and host_gnt=1; host write 0x3C<-0xF5, then read 0x3C -> host_rdata=0xF5 with host_rvalid one cycle after the read.
REQ-032 host_req dropped in HOST -> exactly 1 RELEASE cycle with cpu_hold=1, then RUN with phase=0.
REQ-033 DRAIN with no address phase -> HOST entered after exactly 4 cycles; rst=0 pulsed mid-HOST -> RUN, no write, host_gnt=0.
REQ-034 With SRAM_WRPROT_EN defined, CPU write to 0x10 -> memory unchanged, wp_fault=1; CPU write to 0x50 succeeds.

Source files
------------

// File: rtl/sram_nibble_arbiter.sv
// Purpose: shares a 128x8 async-read SRAM between a nibble-serial CPU and a host port. Optional SRAM_WRPROT_EN write-protects 0x00-0x3F from the CPU.
// Latency: CPU reads/writes and host writes are combinational to the SRAM; host read data returns one cycle after the request.
// Backpressure: the host waits for host_gnt, and the CPU is held in reset (cpu_hold) while the host owns the SRAM.
module sram_nibble_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cpu_out,
    output logic [3:0] cpu_nibble,
    output logic       cpu_hold,
    input  logic       host_req,
    input  logic       host_valid,
    input  logic       host_we,
    input  logic [6:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic       host_gnt,
    output logic [7:0] host_rdata,
    output logic       host_rvalid,
    output logic [6:0] mem_addr,
    output logic       mem_we,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic       wp_fault
);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HOST, S_RELEASE} state_t;

    state_t     state, state_nxt;
    logic       phase, phase_nxt;
    logic [6:0] addr_q, addr_nxt;
    logic [3:0] low_q, low_nxt;
    logic [1:0] drain_cnt, drain_cnt_nxt;
    logic [7:0] rdata_q;
    logic       rvalid_q;
    logic       cpu_active, cpu_wr, cpu_commit, host_acc, wp_hit;

    assign cpu_active = (state == S_RUN) || (state == S_DRAIN);
    assign cpu_wr     = cpu_active && !cpu_out[7] && !cpu_out[5];
    assign cpu_commit = cpu_wr && !phase;
    // A host_valid in the cycle host_req drops is ignored.
    assign host_acc   = (state == S_HOST) && host_req && host_valid;

`ifdef SRAM_WRPROT_EN
    logic wp_q;
    assign wp_hit   = cpu_commit && !addr_q[6];
    assign wp_fault = wp_q;

    always_ff @(posedge clk) begin
        if (!rst) wp_q <= 1'b0;
        else if (wp_hit) wp_q <= 1'b1;
    end
`else
    assign wp_hit   = 1'b0;
    assign wp_fault = 1'b0;
`endif

    assign cpu_nibble  = phase ? mem_rdata[3:0] : mem_rdata[7:4];
    assign cpu_hold    = !rst || (state == S_HOST) || (state == S_RELEASE);
    assign host_gnt    = rst && (state == S_HOST);
    assign host_rdata  = rdata_q;
    assign host_rvalid = rvalid_q;

    always_comb begin
        state_nxt     = state;
        phase_nxt     = phase;
        addr_nxt      = addr_q;
        low_nxt       = low_q;
        drain_cnt_nxt = drain_cnt;
        mem_addr      = addr_q;
        mem_we        = 1'b0;
        mem_wdata     = {cpu_out[3:0], low_q};

        if (cpu_active) begin
            if (cpu_out[7]) begin
                addr_nxt  = cpu_out[6:0];
                phase_nxt = 1'b0;
            end else begin
                phase_nxt = ~phase;
            end
            if (cpu_wr && phase) low_nxt = cpu_out[3:0];
            mem_we = cpu_commit && !wp_hit;
        end

        case (state)
            S_RUN: begin
                if (host_req) begin
                    state_nxt     = S_DRAIN;
                    drain_cnt_nxt = 2'd0;
                end
            end
            S_DRAIN: begin
                if (!host_req)                          state_nxt = S_RUN;
                else if (cpu_out[7] || drain_cnt == 2'd3) state_nxt = S_HOST;
                else                                    drain_cnt_nxt = drain_cnt + 2'd1;
            end
            S_HOST: begin
                mem_addr  = host_addr;
                mem_wdata = host_wdata;
                mem_we    = host_acc && host_we;
                if (!host_req) state_nxt = S_RELEASE;
            end
            default: begin
                state_nxt = S_RUN;
                phase_nxt = 1'b0;
            end
        endcase

        // Reset aborts any in-flight access in the same cycle.
        if (!rst) mem_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_RUN;
            phase     <= 1'b0;
            addr_q    <= 7'd0;
            low_q     <= 4'd0;
            drain_cnt <= 2'd0;
            rdata_q   <= 8'd0;
            rvalid_q  <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase     <= phase_nxt;
            addr_q    <= addr_nxt;
            low_q     <= low_nxt;
            drain_cnt <= drain_cnt_nxt;
            rvalid_q  <= host_acc && !host_we;
            if (host_acc && !host_we) rdata_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_sram_nibble_arbiter.sv
// Bench for sram_nibble_arbiter: behavioural 128x8 SRAM plus a host-read scoreboard queue.
module tb_sram_nibble_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cpu_out;
    logic [3:0] cpu_nibble;
    logic       cpu_hold;
    logic       host_req, host_valid, host_we;
    logic [6:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_gnt;
    logic [7:0] host_rdata;
    logic       host_rvalid;
    logic [6:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       wp_fault;

    logic [7:0] mem [0:127];
    int         we_count;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            we_count = we_count + 1;
        end
    end

    sram_nibble_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_out    (cpu_out),
        .cpu_nibble (cpu_nibble),
        .cpu_hold   (cpu_hold),
        .host_req   (host_req),
        .host_valid (host_valid),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_gnt   (host_gnt),
        .host_rdata (host_rdata),
        .host_rvalid(host_rvalid),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .wp_fault   (wp_fault)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Address phase, idle (phase 0), low nibble (phase 1), high nibble + commit (phase 0).
    task automatic cpu_write(input logic [6:0] a, input logic [7:0] d);
        tick; cpu_out = {1'b1, a};
        tick; cpu_out = 8'h20;
        tick; cpu_out = {4'h0, d[3:0]};
        tick; cpu_out = {4'h0, d[7:4]};
        tick; cpu_out = 8'h20;
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b0; cpu_out = 8'h20;
        host_req = 1'b0; host_valid = 1'b0; host_we = 1'b0;
        host_addr = 7'd0; host_wdata = 8'd0;
        tick; tick; #1;
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL rst_hold: got %b want 1", cpu_hold); end
        checks++; if (host_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt: got %b want 0", host_gnt); end
        checks++; if (host_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b want 0", host_rvalid); end
        checks++; if (host_rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata: got %h want 00", host_rdata); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", mem_we); end
        checks++; if (wp_fault !== 1'b0) begin errors++; $display("FAIL rst_wp: got %b want 0", wp_fault); end
        checks++; if (mem_addr !== 7'h00) begin errors++; $display("FAIL rst_addr: got %h want 00", mem_addr); end
        checks++; if (cpu_nibble !== 4'hA) begin errors++; $display("FAIL rst_phase: got %h want a", cpu_nibble); end
        tick; rst = 1'b1; #1;
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL rst_exit_hold: got %b want 0", cpu_hold); end
    endtask

    task automatic test_cpu_read;
        mem[7'h05] = 8'hF1;
        tick; cpu_out = 8'h85;
        tick; cpu_out = 8'h20; #1;
        checks++; if (mem_addr !== 7'h05) begin errors++; $display("FAIL rd_addr: got %h want 05", mem_addr); end
        checks++; if (cpu_nibble !== 4'hF) begin errors++; $display("FAIL rd_hi: got %h want f", cpu_nibble); end
        tick; #1;
        checks++; if (cpu_nibble !== 4'h1) begin errors++; $display("FAIL rd_lo: got %h want 1", cpu_nibble); end
        tick; #1;
        checks++; if (cpu_nibble !== 4'hF) begin errors++; $display("FAIL rd_toggle: got %h want f", cpu_nibble); end
    endtask

    task automatic test_cpu_write;
        mem[7'h77] = 8'h00; we_count = 0;
        tick; cpu_out = 8'hF7;
        tick; cpu_out = 8'h20;
        tick; cpu_out = 8'h0A; #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL wr_lo_we: got %b want 0", mem_we); end
        tick; cpu_out = 8'h02; #1;
        checks++; if (mem_we !== 1'b1 || mem_wdata !== 8'h2A || mem_addr !== 7'h77) begin
            errors++; $display("FAIL wr_commit: got we=%b d=%h a=%h want 1/2a/77", mem_we, mem_wdata, mem_addr); end
        tick; cpu_out = 8'h20;
        tick;
        checks++; if (mem[7'h77] !== 8'h2A) begin errors++; $display("FAIL wr_mem: got %h want 2a", mem[7'h77]); end
        checks++; if (we_count !== 1) begin errors++; $display("FAIL wr_once: got %0d want 1", we_count); end
    endtask

    task automatic test_host_access;
        tick; cpu_out = 8'h20; host_req = 1'b1; #1;
        checks++; if (cpu_hold !== 1'b0 || host_gnt !== 1'b0) begin errors++; $display("FAIL hs_run: got hold=%b gnt=%b want 0/0", cpu_hold, host_gnt); end
        tick; cpu_out = 8'h20; #1;
        checks++; if (cpu_hold !== 1'b0 || host_gnt !== 1'b0) begin errors++; $display("FAIL hs_drain1: got hold=%b gnt=%b want 0/0", cpu_hold, host_gnt); end
        tick; cpu_out = 8'hF7; #1;
        checks++; if (cpu_hold !== 1'b0 || host_gnt !== 1'b0) begin errors++; $display("FAIL hs_drain2: got hold=%b gnt=%b want 0/0", cpu_hold, host_gnt); end
        tick; cpu_out = 8'h20;
        host_valid = 1'b1; host_we = 1'b1; host_addr = 7'h3C; host_wdata = 8'hF5; #1;
        checks++; if (cpu_hold !== 1'b1 || host_gnt !== 1'b1) begin errors++; $display("FAIL hs_grant: got hold=%b gnt=%b want 1/1", cpu_hold, host_gnt); end
        checks++; if (mem_we !== 1'b1 || mem_addr !== 7'h3C || mem_wdata !== 8'hF5) begin
            errors++; $display("FAIL hs_wr: got we=%b a=%h d=%h want 1/3c/f5", mem_we, mem_addr, mem_wdata); end
        tick; host_we = 1'b0; host_addr = 7'h3C; exp_q.push_back(8'hF5); #1;
        checks++; if (host_rvalid !== 1'b0) begin errors++; $display("FAIL hs_rv_wr: got %b want 0", host_rvalid); end
        tick; host_addr = 7'h05; exp_q.push_back(8'hF1); #1;
        checks++;
        if (host_rvalid !== 1'b1 || exp_q.size() == 0) begin errors++; $display("FAIL hs_rd1: got rvalid=%b want 1", host_rvalid); end
        else begin exp_v = exp_q.pop_front(); if (host_rdata !== exp_v) begin errors++; $display("FAIL hs_rd1: got %h want %h", host_rdata, exp_v); end end
        tick; host_valid = 1'b0; cpu_out = 8'h02; #1;
        checks++;
        if (host_rvalid !== 1'b1 || exp_q.size() == 0) begin errors++; $display("FAIL hs_rd2: got rvalid=%b want 1", host_rvalid); end
        else begin exp_v = exp_q.pop_front(); if (host_rdata !== exp_v) begin errors++; $display("FAIL hs_rd2: got %h want %h", host_rdata, exp_v); end end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL hs_cpu_blocked: got %b want 0", mem_we); end
        tick; cpu_out = 8'h20; #1;
        checks++; if (host_rvalid !== 1'b0 || exp_q.size() != 0) begin
            errors++; $display("FAIL hs_rv_end: got rvalid=%b left=%0d want 0/0", host_rvalid, exp_q.size()); end
    endtask

    task automatic test_release;
        mem[7'h10] = 8'h99;
        host_req = 1'b0; host_valid = 1'b1; host_we = 1'b1; host_addr = 7'h10; host_wdata = 8'h00; #1;
        checks++; if (mem_we !== 1'b0 || host_gnt !== 1'b1) begin errors++; $display("FAIL rl_ignore: got we=%b gnt=%b want 0/1", mem_we, host_gnt); end
        tick; host_valid = 1'b0; host_we = 1'b0; #1;
        checks++; if (cpu_hold !== 1'b1 || host_gnt !== 1'b0) begin errors++; $display("FAIL rl_cycle: got hold=%b gnt=%b want 1/0", cpu_hold, host_gnt); end
        tick; #1;
        checks++; if (cpu_hold !== 1'b0 || cpu_nibble !== 4'h2) begin errors++; $display("FAIL rl_run: got hold=%b nib=%h want 0/2", cpu_hold, cpu_nibble); end
        tick; #1;
        checks++; if (cpu_nibble !== 4'hA) begin errors++; $display("FAIL rl_phase1: got %h want a", cpu_nibble); end
        checks++; if (mem[7'h10] !== 8'h99) begin errors++; $display("FAIL rl_mem: got %h want 99", mem[7'h10]); end
    endtask

    task automatic test_drain_timeout;
        tick; host_req = 1'b1; cpu_out = 8'h20;
        for (int i = 0; i < 4; i++) begin
            tick; #1;
            checks++; if (cpu_hold !== 1'b0 || host_gnt !== 1'b0) begin errors++; $display("FAIL dt_drain%0d: got hold=%b gnt=%b want 0/0", i, cpu_hold, host_gnt); end
        end
        tick; #1;
        checks++; if (host_gnt !== 1'b1 || cpu_hold !== 1'b1) begin errors++; $display("FAIL dt_host: got gnt=%b hold=%b want 1/1", host_gnt, cpu_hold); end
        rst = 1'b0; host_req = 1'b0; host_valid = 1'b1; host_we = 1'b1; host_addr = 7'h3C; host_wdata = 8'h00; #1;
        checks++; if (mem_we !== 1'b0 || host_gnt !== 1'b0) begin errors++; $display("FAIL dt_rst_abort: got we=%b gnt=%b want 0/0", mem_we, host_gnt); end
        tick; rst = 1'b1; host_valid = 1'b0; host_we = 1'b0; #1;
        checks++; if (cpu_hold !== 1'b0 || host_gnt !== 1'b0) begin errors++; $display("FAIL dt_rst_run: got hold=%b gnt=%b want 0/0", cpu_hold, host_gnt); end
        checks++; if (mem[7'h3C] !== 8'hF5) begin errors++; $display("FAIL dt_rst_mem: got %h want f5", mem[7'h3C]); end
    endtask

    task automatic test_drain_abort;
        tick; host_req = 1'b1;
        tick; host_req = 1'b0; #1;
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL da_drain: got %b want 0", cpu_hold); end
        for (int i = 0; i < 3; i++) begin
            tick; #1;
            checks++; if (cpu_hold !== 1'b0 || host_gnt !== 1'b0) begin errors++; $display("FAIL da_run%0d: got hold=%b gnt=%b want 0/0", i, cpu_hold, host_gnt); end
        end
    endtask

    task automatic test_wrprot;
        mem[7'h10] = 8'h99; mem[7'h50] = 8'h00;
        cpu_write(7'h10, 8'h3B);
`ifdef SRAM_WRPROT_EN
        checks++; if (mem[7'h10] !== 8'h99) begin errors++; $display("FAIL wp_mem_lo: got %h want 99", mem[7'h10]); end
        checks++; if (wp_fault !== 1'b1) begin errors++; $display("FAIL wp_flag: got %b want 1", wp_fault); end
`else
        checks++; if (mem[7'h10] !== 8'h3B) begin errors++; $display("FAIL wp_mem_lo: got %h want 3b", mem[7'h10]); end
        checks++; if (wp_fault !== 1'b0) begin errors++; $display("FAIL wp_flag: got %b want 0", wp_fault); end
`endif
        cpu_write(7'h50, 8'h3B);
        checks++; if (mem[7'h50] !== 8'h3B) begin errors++; $display("FAIL wp_mem_hi: got %h want 3b", mem[7'h50]); end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        mem[0] = 8'hA5;
        we_count = 0;
        test_reset;
        test_cpu_read;
        test_cpu_write;
        test_host_access;
        test_release;
        test_drain_timeout;
        test_drain_abort;
        test_wrprot;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
